snax_gemm_csr_mgr: RTL and testbench
====================================

Name: snax_gemm_csr_mgr

Overview:
- Upstream control stage of the SNAX GEMM accelerator.
- Terminates the core's accelerator request/response handshake and decodes CSR reads and writes.
- Holds the operand base addresses (A, B, C) and issues a single-cycle start pulse to the GEMM datapath/streamer.
- Tracks busy status and counts cycles of the last run.

Parameters:
- AddrWidth, 48, width of base-address registers and outputs.
- DataWidth, 64, width of request write data and response read data.
- IdWidth, 5, width of request tag echoed in response.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_write_i  in  1  1 = CSR write (CSRRW), 0 = CSR read.
- req_addr_i  in  32  CSR index (data_arga).
- req_wdata_i  in  DataWidth  write data (data_argb).
- req_id_i  in  IdWidth  request tag.
- qvalid_i  in  1  request valid.
- qready_o  out  1  request ready.
- resp_data_o  out  DataWidth  read data.
- resp_id_o  out  IdWidth  echoed tag.
- resp_error_o  out  1  access error flag.
- pvalid_o  out  1  response valid.
- pready_i  in  1  response ready.
- addr_a_o  out  AddrWidth  base address A.
- addr_b_o  out  AddrWidth  base address B.
- addr_c_o  out  AddrWidth  base address C.
- start_o  out  1  one-cycle start pulse to GEMM.
- done_i  in  1  one-cycle completion pulse from GEMM.

Behaviour:
- Reset (async, rst_i=1): all outputs and registers = 0 (addr_*_o=0, start_o=0, pvalid_o=0, running=0, perf=0). Reset mid-run drops running, pending response and counter immediately; a done_i arriving after reset is ignored.
- CSR map:
  - 0 = A base (RW).
  - 1 = B base (RW).
  - 2 = C base (RW).
  - 3 = START (WO; reads return 0, no error).
  - 4 = STATUS (RO; bit0 = running, other bits 0).
  - 5 = PERF (RO; cycle count of current/last run, zero-extended).
  - Index > 5 is an error.
- Handshake:
  - Request accepted when qvalid_i & qready_o. qready_o = ~pvalid_o | pready_i (single response slot; back-to-back accepts allowed while the response drains).
  - Every accepted request yields exactly one response, presented on the cycle after accept.
  - pvalid_o and the resp_* fields hold stable until pvalid_o & pready_i. pvalid_o falls the cycle after a handshake unless a new accept occurred in that same cycle.
- Writes to 0..2:
  - Register <= req_wdata_i[AddrWidth-1:0] (upper bits dropped), visible on addr_*_o the cycle after accept.
  - If running=1 at accept: write is ignored and resp_error_o=1.
- Write to 3:
  - If running=0 at accept: start_o=1 for exactly the next cycle, running<=1, perf<=0. Write data is ignored.
  - If running=1: no pulse, resp_error_o=1.
- Writes to 4 or 5: ignored, resp_error_o=1.
- Reads:
  - resp_data_o = register value zero-extended to DataWidth.
  - Errors return resp_data_o=0.
  - Write responses carry resp_data_o=0.
- running:
  - Set by an accepted start; cleared on the cycle after done_i.
  - done_i while running=0 is ignored.
  - done_i in the same cycle a start write is accepted: running was 1, so the start is rejected with error; running clears normally.
- perf: increments by 1 every cycle running=1, including the start_o cycle; stops incrementing once running clears and holds its value until the next accepted start. Saturates at all-ones (32-bit internal counter).
- Single state machine, IDLE / RUN, derived from running. The response slot is an independent full/empty flag.

Test Plan:
- After reset: qready_o=1, pvalid_o=0, addr_*_o=0, STATUS read -> resp_data_o=0, resp_error_o=0, resp_id_o echoes id 7.
- Write CSR0=0x80, CSR1=0x280, CSR2=0x480 with ids 1,2,3 -> addr_a_o/b_o/c_o = 0x80/0x280/0x480 one cycle after each accept; three responses, error=0, ids 1,2,3; reads of 0..2 return same values.
- Write CSR3=0x280 -> start_o high exactly one cycle; STATUS reads 1. Assert done_i 20 cycles after start_o -> STATUS reads 0 and PERF reads 21 (counted from the start_o cycle through the done_i cycle). Second done_i is ignored.
- While running: write CSR0=0x1234 and CSR3 -> both respond error=1, addr_a_o unchanged, no start_o pulse.
- Hold pready_i=0 with qvalid_i=1: first request accepted, qready_o drops, response fields stable for 5 cycles. Raise pready_i -> the second request is accepted the same cycle, and its response appears the next cycle.
- Read CSR 9 -> error=1, data=0. Write CSR 4 -> error=1. Assert rst_i mid-run with a response pending -> pvalid_o=0, addr_*_o=0, running=0 immediately.

Source files
------------

// File: rtl/snax_gemm_csr_mgr_if.sv
// Accelerator request/response handshake between the core and the GEMM CSR manager.
// The core side is the master: it issues requests and accepts responses.
interface snax_gemm_csr_mgr_if #(
    parameter int DataWidth = 64,
    parameter int IdWidth   = 5
);
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [DataWidth-1:0] req_wdata;
    logic [IdWidth-1:0]   req_id;
    logic                 qvalid;
    logic                 qready;

    logic [DataWidth-1:0] resp_data;
    logic [IdWidth-1:0]   resp_id;
    logic                 resp_error;
    logic                 pvalid;
    logic                 pready;

    modport master (
        output req_write, req_addr, req_wdata, req_id, qvalid, pready,
        input  qready, resp_data, resp_id, resp_error, pvalid
    );

    modport slave (
        input  req_write, req_addr, req_wdata, req_id, qvalid, pready,
        output qready, resp_data, resp_id, resp_error, pvalid
    );
endinterface

// File: rtl/snax_gemm_csr_mgr.sv
// GEMM CSR manager: decodes core CSR accesses, holds operand base addresses,
// launches the datapath with a one-cycle start pulse and times each run.
//
// state | meaning
// IDLE  | no run in flight; START writes are accepted
// RUN   | GEMM busy from the start_o cycle until the cycle after done_i
module snax_gemm_csr_mgr #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    snax_gemm_csr_mgr_if.slave   csr,
    output logic [AddrWidth-1:0] addr_a_o,
    output logic [AddrWidth-1:0] addr_b_o,
    output logic [AddrWidth-1:0] addr_c_o,
    output logic                 start_o,
    input  logic                 done_i
);

    localparam logic [31:0] CsrAddrA  = 32'd0;
    localparam logic [31:0] CsrAddrB  = 32'd1;
    localparam logic [31:0] CsrAddrC  = 32'd2;
    localparam logic [31:0] CsrStart  = 32'd3;
    localparam logic [31:0] CsrStatus = 32'd4;
    localparam logic [31:0] CsrPerf   = 32'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   running;

    logic                 accept;
    logic                 start_accept;
    logic                 wr_a;
    logic                 wr_b;
    logic                 wr_c;
    logic                 start_req;
    logic [DataWidth-1:0] rsp_data;
    logic                 rsp_err;

    logic [AddrWidth-1:0] addr_a_q;
    logic [AddrWidth-1:0] addr_b_q;
    logic [AddrWidth-1:0] addr_c_q;
    logic                 start_q;
    logic [31:0]          perf_q;

    logic                 pvalid_q;
    logic [DataWidth-1:0] resp_data_q;
    logic [IdWidth-1:0]   resp_id_q;
    logic                 resp_error_q;

    // Base registers only keep the low AddrWidth bits of the write data.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^csr.req_wdata[DataWidth-1:AddrWidth];

    // Single response slot: a new request may enter while the old response drains.
    assign csr.qready = ~pvalid_q | csr.pready;
    assign accept     = csr.qvalid & csr.qready;

    always_comb begin
        rsp_data  = '0;
        rsp_err   = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        wr_c      = 1'b0;
        start_req = 1'b0;
        if (csr.req_write) begin
            case (csr.req_addr)
                CsrAddrA: begin
                    if (running) rsp_err = 1'b1;
                    else         wr_a    = 1'b1;
                end
                CsrAddrB: begin
                    if (running) rsp_err = 1'b1;
                    else         wr_b    = 1'b1;
                end
                CsrAddrC: begin
                    if (running) rsp_err = 1'b1;
                    else         wr_c    = 1'b1;
                end
                CsrStart: begin
                    if (running) rsp_err   = 1'b1;
                    else         start_req = 1'b1;
                end
                default: rsp_err = 1'b1;
            endcase
        end else begin
            case (csr.req_addr)
                CsrAddrA:  rsp_data = DataWidth'(addr_a_q);
                CsrAddrB:  rsp_data = DataWidth'(addr_b_q);
                CsrAddrC:  rsp_data = DataWidth'(addr_c_q);
                CsrStart:  rsp_data = '0;
                CsrStatus: rsp_data = DataWidth'(running);
                CsrPerf:   rsp_data = DataWidth'(perf_q);
                default:   rsp_err  = 1'b1;
            endcase
        end
    end

    assign start_accept = accept & start_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A done_i coinciding with a START request sees RUN, so that start is refused.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_accept) state_d = RUN;
            RUN:  if (done_i)       state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
        end else if (accept) begin
            if (wr_a) addr_a_q <= csr.req_wdata[AddrWidth-1:0];
            if (wr_b) addr_b_q <= csr.req_wdata[AddrWidth-1:0];
            if (wr_c) addr_c_q <= csr.req_wdata[AddrWidth-1:0];
        end
    end

    // perf counts every RUN cycle, including the start_o cycle, and saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q <= 1'b0;
            perf_q  <= '0;
        end else begin
            start_q <= start_accept;
            if (start_accept) begin
                perf_q <= '0;
            end else if (running && (perf_q != '1)) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pvalid_q     <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_error_q <= 1'b0;
        end else if (accept) begin
            pvalid_q     <= 1'b1;
            resp_data_q  <= rsp_data;
            resp_id_q    <= csr.req_id;
            resp_error_q <= rsp_err;
        end else if (csr.pready) begin
            pvalid_q     <= 1'b0;
        end
    end

    assign csr.pvalid     = pvalid_q;
    assign csr.resp_data  = resp_data_q;
    assign csr.resp_id    = resp_id_q;
    assign csr.resp_error = resp_error_q;

    assign addr_a_o = addr_a_q;
    assign addr_b_o = addr_b_q;
    assign addr_c_o = addr_c_q;
    assign start_o  = start_q;

endmodule

// File: tb/tb_snax_gemm_csr_mgr.sv
// Bench for the GEMM CSR manager: a passive reference model predicts every
// response from the CSR rules, a separate monitor checks what the DUT presents.
module tb_snax_gemm_csr_mgr;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snax_gemm_csr_mgr_if #(.DataWidth(DW), .IdWidth(IW)) bus ();

    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_c;
    logic          start;
    logic          done;

    logic done_dir   = 1'b0;
    logic done_rnd   = 1'b0;
    logic pready_dir = 1'b1;
    logic pready_rnd = 1'b1;
    bit   rand_mode  = 1'b0;

    assign done       = rand_mode ? done_rnd : done_dir;
    assign bus.pready = rand_mode ? pready_rnd : pready_dir;

    snax_gemm_csr_mgr #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .csr      (bus),
        .addr_a_o (addr_a),
        .addr_b_o (addr_b),
        .addr_c_o (addr_c),
        .start_o  (start),
        .done_i   (done)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: run window [s_cyc, d_cyc] in cycle numbers.
    logic [AW-1:0] m_reg [3];
    bit     have_run  = 1'b0;
    bit     done_seen = 1'b0;
    longint s_cyc     = 0;
    longint d_cyc     = 0;

    function automatic bit running_at(input longint t);
        return have_run && (t >= s_cyc) && (!done_seen || t <= d_cyc);
    endfunction

    function automatic logic [63:0] perf_at(input longint t);
        if (!have_run)               return 64'd0;
        if (done_seen && t > d_cyc)  return 64'(d_cyc - s_cyc + 1);
        return 64'(t - s_cyc);
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        longint        acc;
    } rsp_t;

    rsp_t sb[$];

    always @(negedge clk) begin
        bit          run_t;
        rsp_t        e;
        logic [31:0] idx;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_reg[i] = '0;
            have_run  = 1'b0;
            done_seen = 1'b0;
            sb.delete();
        end else begin
            run_t = running_at(cyc);
            if (bus.qvalid && bus.qready) begin
                idx    = bus.req_addr;
                e.data = '0;
                e.err  = 1'b0;
                e.id   = bus.req_id;
                e.acc  = cyc;
                if (bus.req_write) begin
                    if (idx < 32'd3) begin
                        if (run_t) e.err = 1'b1;
                        else       m_reg[idx[1:0]] = bus.req_wdata[AW-1:0];
                    end else if (idx == 32'd3) begin
                        if (run_t) e.err = 1'b1;
                        else begin
                            have_run  = 1'b1;
                            done_seen = 1'b0;
                            s_cyc     = cyc + 1;
                        end
                    end else begin
                        e.err = 1'b1;
                    end
                end else begin
                    if (idx < 32'd3)       e.data = {16'h0, m_reg[idx[1:0]]};
                    else if (idx == 32'd3) e.data = '0;
                    else if (idx == 32'd4) e.data = {63'h0, run_t};
                    else if (idx == 32'd5) e.data = perf_at(cyc);
                    else                   e.err  = 1'b1;
                end
                e.a = m_reg[0];
                e.b = m_reg[1];
                e.c = m_reg[2];
                sb.push_back(e);
            end
            if (done && run_t) begin
                done_seen = 1'b1;
                d_cyc     = cyc;
            end
        end
    end

    // Monitor: compares presented responses (every held cycle) against the queue head.
    bit prev_pv = 1'b0;
    bit prev_hs = 1'b0;
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            prev_pv = 1'b0;
            prev_hs = 1'b0;
        end else begin
            check("qready", 64'(bus.qready), 64'(!bus.pvalid || bus.pready));
            check("start_o", 64'(start), 64'(have_run && cyc == s_cyc));
            if (bus.pvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected response", 64'(bus.pvalid), 64'd0);
                end else begin
                    e = sb[0];
                    if (!prev_pv || prev_hs) check("resp latency", 64'(cyc - e.acc), 64'd1);
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_id", 64'(bus.resp_id), 64'(e.id));
                    check("resp_error", 64'(bus.resp_error), 64'(e.err));
                    check("addr_a", 64'(addr_a), 64'(e.a));
                    check("addr_b", 64'(addr_b), 64'(e.b));
                    check("addr_c", 64'(addr_c), 64'(e.c));
                    if (bus.pready) void'(sb.pop_front());
                end
            end
            prev_pv = bus.pvalid;
            prev_hs = bus.pvalid && bus.pready;
        end
    end

    always @(posedge clk) begin
        #1;
        pready_rnd = ($urandom_range(0, 3) != 0);
        done_rnd   = ($urandom_range(0, 24) == 0);
    end

    // Called just after a rising edge; returns one edge after the accept.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [63:0] d,
                         input logic [IW-1:0] id, output longint acc);
        int n;
        n = 0;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_id    = id;
        bus.qvalid    = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.qready) break;
            n++;
            if (n > 200) begin
                check("accept timeout", 64'(bus.qready), 64'd1);
                break;
            end
        end
        acc = cyc;
        @(posedge clk);
        #1;
        bus.qvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done();
        done_dir = 1'b1;
        idle(1);
        done_dir = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc;
        longint acc2;
        longint s;
        logic [31:0] ra;
        bus.qvalid    = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_id    = '0;
        idle(3);
        check("rst addr_a", 64'(addr_a), 64'd0);
        rst = 1'b0;
        #1;
        check("reset qready", 64'(bus.qready), 64'd1);
        check("reset pvalid", 64'(bus.pvalid), 64'd0);
        check("reset addr_b", 64'(addr_b), 64'd0);
        check("reset addr_c", 64'(addr_c), 64'd0);
        check("reset start", 64'(start), 64'd0);
        idle(1);
        issue(1'b0, 32'd4, 64'd0, 5'd7, acc);

        issue(1'b1, 32'd0, 64'h80, 5'd1, acc);
        check("addr_a after write", 64'(addr_a), 64'h80);
        issue(1'b1, 32'd1, 64'h280, 5'd2, acc);
        check("addr_b after write", 64'(addr_b), 64'h280);
        issue(1'b1, 32'd2, 64'hFFFF_0000_0000_0480, 5'd3, acc);
        check("addr_c after write", 64'(addr_c), 64'h480);
        for (int i = 0; i < 3; i++) issue(1'b0, 32'(i), 64'd0, 5'(i + 1), acc);

        issue(1'b1, 32'd3, 64'h280, 5'd4, acc);
        s = acc + 1;
        check("start pulse", 64'(start), 64'd1);
        issue(1'b0, 32'd4, 64'd0, 5'd5, acc);
        while (cyc < s + 20) idle(1);
        pulse_done();
        issue(1'b0, 32'd4, 64'd0, 5'd6, acc);
        issue(1'b0, 32'd5, 64'd0, 5'd8, acc);
        pulse_done();
        issue(1'b0, 32'd4, 64'd0, 5'd9, acc);
        issue(1'b0, 32'd5, 64'd0, 5'd10, acc);

        issue(1'b1, 32'd3, 64'd0, 5'd11, acc);
        issue(1'b1, 32'd0, 64'h1234, 5'd12, acc);
        issue(1'b1, 32'd3, 64'd0, 5'd13, acc);
        idle(2);
        check("addr_a held while running", 64'(addr_a), 64'h80);
        issue(1'b0, 32'd5, 64'd0, 5'd14, acc);
        pulse_done();
        idle(2);

        pready_dir = 1'b0;
        issue(1'b0, 32'd1, 64'd0, 5'd15, acc);
        fork
            issue(1'b0, 32'd2, 64'd0, 5'd16, acc2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("qready held low", 64'(bus.qready), 64'd0);
                end
                @(posedge clk);
                #1;
                pready_dir = 1'b1;
            end
        join
        idle(2);

        issue(1'b0, 32'd9, 64'd0, 5'd17, acc);
        issue(1'b1, 32'd4, 64'h55, 5'd18, acc);
        issue(1'b1, 32'd5, 64'h55, 5'd19, acc);
        issue(1'b0, 32'hFFFF_FFFF, 64'd0, 5'd20, acc);

        issue(1'b1, 32'd3, 64'd0, 5'd21, acc);
        idle(2);
        pready_dir = 1'b0;
        issue(1'b0, 32'd5, 64'd0, 5'd22, acc);
        rst = 1'b1;
        #1;
        check("mid-run reset pvalid", 64'(bus.pvalid), 64'd0);
        check("mid-run reset addr_a", 64'(addr_a), 64'd0);
        check("mid-run reset addr_b", 64'(addr_b), 64'd0);
        check("mid-run reset addr_c", 64'(addr_c), 64'd0);
        check("mid-run reset start", 64'(start), 64'd0);
        idle(2);
        rst        = 1'b0;
        pready_dir = 1'b1;
        pulse_done();
        issue(1'b0, 32'd4, 64'd0, 5'd23, acc);
        issue(1'b0, 32'd5, 64'd0, 5'd24, acc);
        issue(1'b0, 32'd0, 64'd0, 5'd25, acc);

        rand_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            idle($urandom_range(0, 2));
            ra = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            issue(1'b1 & ($urandom_range(0, 1) != 0), ra, {$urandom, $urandom},
                  IW'($urandom_range(0, 31)), acc);
        end
        rand_mode = 1'b0;

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
